// File: rtl/prog_seq_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : prog_seq_updown_counter
// Description : Up/down counter over a programmable table of sequence codes.
//               The active length is selectable. At the table ends it wraps or saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_seq_updown_counter #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 7,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             count_en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic [LEN_W-1:0] seq_len,
    input  logic [WIDTH-1:0] data_in,
    input  logic             tbl_we,
    input  logic [IDX_W-1:0] tbl_addr,
    input  logic [WIDTH-1:0] tbl_data,
    output logic [WIDTH-1:0] count,
    output logic [IDX_W-1:0] idx,
    output logic             at_end,
    output logic             tc,
    output logic             load_miss
);

    localparam logic [LEN_W-1:0] c_DEPTH_L = LEN_W'(DEPTH);

    logic [WIDTH-1:0] r_tbl [DEPTH];
    logic [IDX_W-1:0] r_idx;
    logic             r_tc;
    logic             r_miss;

    logic [LEN_W-1:0] w_len;
    logic [LEN_W-1:0] w_last;
    logic [LEN_W-1:0] w_idx_ext;
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic [WIDTH-1:0] w_count;

    // Zero or an out-of-range length selects the full table.
    assign w_len     = (seq_len == '0 || seq_len > c_DEPTH_L) ? c_DEPTH_L : seq_len;
    assign w_last    = w_len - LEN_W'(1);
    assign w_idx_ext = LEN_W'(r_idx);

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (LEN_W'(i) < w_len && r_tbl[i] == data_in) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_idx == IDX_W'(i)) w_count = r_tbl[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_tbl[i] <= WIDTH'(i);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tbl_we && tbl_addr == IDX_W'(i)) r_tbl[i] <= tbl_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_tc   <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            r_tc   <= 1'b0;
            r_miss <= 1'b0;
            if (load) begin
                r_idx  <= w_hit ? w_hit_idx : '0;
                r_miss <= ~w_hit;
            end else if (count_en) begin
                if (w_idx_ext >= w_len) begin
                    r_idx <= '0;
                end else if (up) begin
                    if (w_idx_ext == w_last) begin
                        if (!sat_mode) begin
                            r_idx <= '0;
                            r_tc  <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end else begin
                    if (r_idx == '0) begin
                        if (!sat_mode) begin
                            r_idx <= IDX_W'(w_last);
                            r_tc  <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
            end
        end
    end

    assign count     = w_count;
    assign idx       = r_idx;
    assign tc        = r_tc;
    assign load_miss = r_miss;
    assign at_end    = up ? (w_idx_ext == w_last) : (r_idx == '0);

endmodule
`default_nettype wire

// File: tb/tb_prog_seq_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_seq_updown_counter
// Description : Directed and randomized checks of prog_seq_updown_counter against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_seq_updown_counter;

    localparam int WIDTH = 4;
    localparam int DEPTH = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       load, count_en, up, sat_mode, tbl_we;
    logic [2:0] seq_len, tbl_addr;
    logic [3:0] data_in, tbl_data;
    logic [3:0] count;
    logic [2:0] idx;
    logic       at_end, tc, load_miss;

    always #5 clk = ~clk;

    prog_seq_updown_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load(load), .count_en(count_en), .up(up),
        .sat_mode(sat_mode), .seq_len(seq_len), .data_in(data_in),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .count(count), .idx(idx), .at_end(at_end), .tc(tc), .load_miss(load_miss)
    );

    int m_tbl [DEPTH];
    int m_idx;
    bit m_tc, m_miss;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int eff_len();
        return (seq_len == 0 || int'(seq_len) > DEPTH) ? DEPTH : int'(seq_len);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % 16;
        m_idx  = 0;
        m_tc   = 0;
        m_miss = 0;
    endtask

    // Reference behaviour of one rising edge, using the inputs as driven before it.
    task automatic model_edge();
        int L;
        int found;
        L      = eff_len();
        m_tc   = 0;
        m_miss = 0;
        if (load) begin
            found = -1;
            for (int i = 0; i < L; i++)
                if (found < 0 && m_tbl[i] == int'(data_in)) found = i;
            if (found >= 0) m_idx = found;
            else begin m_idx = 0; m_miss = 1; end
        end else if (count_en) begin
            if (m_idx >= L) m_idx = 0;
            else if (up) begin
                if (!(sat_mode && m_idx == L - 1)) begin
                    m_tc  = (m_idx == L - 1);
                    m_idx = (m_idx + 1) % L;
                end
            end else begin
                if (!(sat_mode && m_idx == 0)) begin
                    m_tc  = (m_idx == 0);
                    m_idx = (m_idx + L - 1) % L;
                end
            end
        end
        if (tbl_we && int'(tbl_addr) < DEPTH) m_tbl[tbl_addr] = int'(tbl_data);
    endtask

    task automatic check_all(input string tag);
        int L;
        L = eff_len();
        check({tag, ".idx"},       idx,       m_idx);
        check({tag, ".count"},     count,     m_tbl[m_idx]);
        check({tag, ".tc"},        tc,        m_tc);
        check({tag, ".load_miss"}, load_miss, m_miss);
        check({tag, ".at_end"},    at_end,    up ? (m_idx == L - 1) : (m_idx == 0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    int leg  [DEPTH] = '{0, 1, 2, 3, 8, 9, 10};
    int exp2 [8]     = '{1, 2, 3, 8, 9, 10, 0, 1};
    int exp3 [4]     = '{10, 9, 8, 3};
    int tc_seen;

    initial begin
        reset = 1'b0; load = 0; count_en = 0; up = 1; sat_mode = 0; tbl_we = 0;
        seq_len = 3'd7; tbl_addr = 0; data_in = 0; tbl_data = 0;
        model_reset();
        #3;
        check("rst.idx", idx, 0);
        check("rst.count", count, 0);
        check("rst.tc", tc, 0);
        check("rst.load_miss", load_miss, 0);
        @(negedge clk) reset = 1'b1;

        // Legacy table, forward run with a single wrap.
        for (int i = 0; i < DEPTH; i++) begin
            tbl_we = 1; tbl_addr = 3'(i); tbl_data = 4'(leg[i]);
            step("t2w");
        end
        tbl_we = 0; count_en = 1; tc_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step("t2");
            check("t2.seq", count, exp2[i]);
            if (tc) begin
                tc_seen++;
                check("t2.tc_at_zero", count, 0);
            end
        end
        check("t2.tc_once", tc_seen, 1);

        // Reverse wrap from code 0.
        count_en = 0; load = 1; data_in = 4'd0;
        step("t3l");
        load = 0; up = 0; count_en = 1;
        for (int i = 0; i < 4; i++) begin
            step("t3");
            check("t3.seq", count, exp3[i]);
            check("t3.tc", tc, (i == 0));
        end

        // Saturation at the top.
        count_en = 0; load = 1; data_in = 4'd9;
        step("t4l");
        load = 0; sat_mode = 1; up = 1; count_en = 1;
        for (int i = 0; i < 3; i++) begin
            step("t4");
            check("t4.count", count, 10);
            check("t4.tc", tc, 0);
            check("t4.at_end", at_end, 1);
        end

        // Load hit, miss, and priority over count.
        sat_mode = 0; count_en = 0; load = 1; data_in = 4'd8;
        step("t5a");
        check("t5a.idx", idx, 4); check("t5a.count", count, 8); check("t5a.miss", load_miss, 0);
        data_in = 4'd5;
        step("t5b");
        check("t5b.idx", idx, 0); check("t5b.count", count, 0); check("t5b.miss", load_miss, 1);
        load = 0;
        step("t5c");
        check("t5c.miss", load_miss, 0);
        load = 1; count_en = 1; up = 1; data_in = 4'd3;
        step("t5d");
        check("t5d.idx", idx, 3);

        // Length shrink leaves idx off-path, then a write to the current entry.
        count_en = 0; data_in = 4'd10;
        step("t6l");
        check("t6l.idx", idx, 6);
        load = 0; seq_len = 3'd3; count_en = 1;
        step("t6");
        check("t6.idx", idx, 0); check("t6.tc", tc, 0);
        count_en = 0; tbl_we = 1; tbl_addr = 3'd0; tbl_data = 4'hF;
        step("t6w");
        check("t6w.count", count, 15);
        tbl_we = 0;

        for (int n = 0; n < 600; n++) begin
            load     = ($urandom_range(0, 7) == 0);
            count_en = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            sat_mode = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) seq_len = 3'($urandom_range(0, 7));
            data_in  = 4'($urandom);
            tbl_we   = ($urandom_range(0, 7) == 0);
            tbl_addr = 3'($urandom_range(0, 7));
            tbl_data = 4'($urandom);
            step("rnd");
        end

        // Asynchronous reset in the middle of a counting cycle.
        load = 0; tbl_we = 0; count_en = 1; up = 1; sat_mode = 0; seq_len = 3'd0;
        step("t1a");
        step("t1b");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("t1.idx", idx, 0);
        check("t1.count", count, 0);
        check("t1.tc", tc, 0);
        check("t1.load_miss", load_miss, 0);
        @(negedge clk) reset = 1'b1;
        step("t1post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
